// File: rtl/intr_ctrl.sv
// Prioritised interrupt controller. Each source passes through a gateway
// (level or rising-edge trigger, pending / in-service tracking); a registered
// arbiter picks the highest-priority enabled pending source above the
// threshold. Software claims and completes interrupts through a small
// register port with a one-cycle response.
module intr_ctrl #(
   parameter int NumSrc    = 64,
   parameter int PrioWidth = 3,
   parameter int IdWidth   = $clog2(NumSrc + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NumSrc-1:0]  src_i,
   input  logic               reg_req_i,
   input  logic               reg_we_i,
   input  logic [11:0]        reg_addr_i,
   input  logic [31:0]        reg_wdata_i,
   output logic               reg_rvalid_o,
   output logic [31:0]        reg_rdata_o,
   output logic               reg_err_o,
   output logic               irq_o,
   output logic [IdWidth-1:0] irq_id_o
);

   localparam int NumWords = (NumSrc + 31) / 32;

   // Bit i of each vector belongs to source ID i+1.
   logic [NumSrc-1:0]    pending_q, in_service_q, enable_q, mode_q, src_q;
   logic [PrioWidth-1:0] prio_q [NumSrc];
   logic [PrioWidth-1:0] threshold_q;

   logic                 aligned;
   logic [5:0]           bit_word;
   logic [7:0]           prio_idx;
   logic                 sel_pending, sel_enable, sel_mode, sel_prio;
   logic                 sel_thresh, sel_claim, addr_hit;
   logic                 rd_en, wr_en;

   logic                 claim, complete;
   logic [IdWidth-1:0]   cmp_id;

   logic [NumSrc-1:0]    rd_vec;
   logic [31:0]          rdata_nxt;

   logic [NumSrc-1:0]    trig;
   logic [NumSrc-1:0]    pending_d, in_service_d, enable_d, mode_d;
   logic [PrioWidth-1:0] prio_d [NumSrc];
   logic [PrioWidth-1:0] threshold_d;

   logic [IdWidth-1:0]   best_id;
   logic [PrioWidth-1:0] best_prio;

   // Decode the current access into one register group, or none.
   always_comb begin
      aligned     = (reg_addr_i[1:0] == 2'b00);
      bit_word    = reg_addr_i[7:2];
      prio_idx    = reg_addr_i[9:2];
      sel_pending = aligned && (reg_addr_i[11:8] == 4'h0) && (int'(bit_word) < NumWords);
      sel_enable  = aligned && (reg_addr_i[11:8] == 4'h1) && (int'(bit_word) < NumWords);
      sel_mode    = aligned && (reg_addr_i[11:8] == 4'h2) && (int'(bit_word) < NumWords);
      sel_prio    = aligned && (reg_addr_i[11:10] == 2'b01) && (int'(prio_idx) < NumSrc);
      sel_thresh  = (reg_addr_i == 12'h800);
      sel_claim   = (reg_addr_i == 12'h804);
      addr_hit    = sel_pending || sel_enable || sel_mode || sel_prio || sel_thresh || sel_claim;
      rd_en       = reg_req_i && !reg_we_i;
      wr_en       = reg_req_i && reg_we_i;
   end

   // Claim uses the registered winner; a zero ID claim does nothing.
   always_comb begin
      cmp_id   = reg_wdata_i[IdWidth-1:0];
      claim    = rd_en && sel_claim && (irq_id_o != '0);
      complete = wr_en && sel_claim && (cmp_id != '0) && (int'(cmp_id) <= NumSrc);
   end

   // Read data mux; unmapped reads and bits beyond NumSrc return zero.
   always_comb begin
      rd_vec = pending_q;
      if (sel_enable) begin
         rd_vec = enable_q;
      end else if (sel_mode) begin
         rd_vec = mode_q;
      end
      rdata_nxt = '0;
      if (rd_en) begin
         if (sel_pending || sel_enable || sel_mode) begin
            for (int i = 0; i < NumSrc; i++) begin
               if (i / 32 == int'(bit_word)) begin
                  rdata_nxt[i % 32] = rd_vec[i];
               end
            end
         end else if (sel_prio) begin
            for (int i = 0; i < NumSrc; i++) begin
               if (i == int'(prio_idx)) begin
                  rdata_nxt[PrioWidth-1:0] = prio_q[i];
               end
            end
         end else if (sel_thresh) begin
            rdata_nxt[PrioWidth-1:0] = threshold_q;
         end else if (sel_claim) begin
            rdata_nxt[IdWidth-1:0] = irq_id_o;
         end
      end
   end

   // Gateway and configuration next state. The trigger uses the current
   // (old) mode, so a same-cycle MODE write only affects the next cycle.
   // A trigger on a pending or in-service source is dropped, which also
   // makes a claim or complete win over a same-cycle trigger.
   always_comb begin
      trig         = src_i & ~(src_q & mode_q);
      pending_d    = pending_q | (trig & ~in_service_q);
      in_service_d = in_service_q;
      enable_d     = enable_q;
      mode_d       = mode_q;
      prio_d       = prio_q;
      threshold_d  = threshold_q;
      for (int i = 0; i < NumSrc; i++) begin
         if (claim && (int'(irq_id_o) == i + 1)) begin
            pending_d[i]    = 1'b0;
            in_service_d[i] = 1'b1;
         end
         if (complete && (int'(cmp_id) == i + 1)) begin
            in_service_d[i] = 1'b0;
         end
         if (wr_en && sel_enable && (i / 32 == int'(bit_word))) begin
            enable_d[i] = reg_wdata_i[i % 32];
         end
         if (wr_en && sel_mode && (i / 32 == int'(bit_word))) begin
            mode_d[i] = reg_wdata_i[i % 32];
         end
         if (wr_en && sel_prio && (i == int'(prio_idx))) begin
            prio_d[i] = reg_wdata_i[PrioWidth-1:0];
         end
      end
      if (wr_en && sel_thresh) begin
         threshold_d = reg_wdata_i[PrioWidth-1:0];
      end
   end

   // Arbiter: starting the running best at the threshold makes the
   // candidate test strict; scanning upward with '>' keeps the lowest ID on ties.
   always_comb begin
      best_id   = '0;
      best_prio = threshold_q;
      for (int i = 0; i < NumSrc; i++) begin
         if (pending_q[i] && enable_q[i] && (prio_q[i] > best_prio)) begin
            best_prio = prio_q[i];
            best_id   = IdWidth'(i + 1);
         end
      end
   end

   // State, arbitration result and register response registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pending_q    <= '0;
         in_service_q <= '0;
         enable_q     <= '0;
         mode_q       <= '0;
         src_q        <= '0;
         for (int i = 0; i < NumSrc; i++) begin
            prio_q[i] <= '0;
         end
         threshold_q  <= '0;
         irq_id_o     <= '0;
         irq_o        <= 1'b0;
         reg_rvalid_o <= 1'b0;
         reg_rdata_o  <= '0;
         reg_err_o    <= 1'b0;
      end else begin
         pending_q    <= pending_d;
         in_service_q <= in_service_d;
         enable_q     <= enable_d;
         mode_q       <= mode_d;
         src_q        <= src_i;
         prio_q       <= prio_d;
         threshold_q  <= threshold_d;
         irq_id_o     <= best_id;
         irq_o        <= (best_id != '0);
         reg_rvalid_o <= reg_req_i;
         reg_rdata_o  <= addr_hit ? rdata_nxt : '0;
         reg_err_o    <= reg_req_i && !addr_hit;
      end
   end

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios followed by a randomized phase,
// with a behavioural model of the controller compared every cycle.
module tb_intr_ctrl;

   localparam int NS = 64;
   localparam int IW = 7;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic [NS-1:0] src   = '0;
   logic          req   = 1'b0;
   logic          we    = 1'b0;
   logic [11:0]   addr  = '0;
   logic [31:0]   wdata = '0;
   logic          rvalid, err, irq;
   logic [31:0]   rdata;
   logic [IW-1:0] irq_id;

   int n_assert = 0;
   int n_fail   = 0;

   intr_ctrl #(.NumSrc(NS), .PrioWidth(3)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .src_i        (src),
      .reg_req_i    (req),
      .reg_we_i     (we),
      .reg_addr_i   (addr),
      .reg_wdata_i  (wdata),
      .reg_rvalid_o (rvalid),
      .reg_rdata_o  (rdata),
      .reg_err_o    (err),
      .irq_o        (irq),
      .irq_id_o     (irq_id)
   );

   always #5 clk = ~clk;

   // Model state, indexed by interrupt ID.
   bit          m_pend [1:NS];
   bit          m_insv [1:NS];
   bit          m_en   [1:NS];
   bit          m_mode [1:NS];
   bit          m_srcq [1:NS];
   int          m_prio [1:NS];
   int          m_thr;
   int          m_id;
   bit          e_rvalid;
   bit          e_err;
   logic [31:0] e_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock using the inputs present at the edge.
   task automatic model_step();
      bit np [1:NS];
      bit ni [1:NS];
      bit trig;
      int best, nid, a, w, k, cid;
      e_rvalid = req;
      e_err    = 1'b0;
      e_rdata  = '0;
      if (rst) begin
         for (int i = 1; i <= NS; i++) begin
            m_pend[i] = 0; m_insv[i] = 0; m_en[i] = 0;
            m_mode[i] = 0; m_srcq[i] = 0; m_prio[i] = 0;
         end
         m_thr    = 0;
         m_id     = 0;
         e_rvalid = 1'b0;
         return;
      end
      nid  = 0;
      best = m_thr;
      for (int i = 1; i <= NS; i++) begin
         if (m_pend[i] && m_en[i] && m_prio[i] > best) begin
            best = m_prio[i];
            nid  = i;
         end
      end
      for (int i = 1; i <= NS; i++) begin
         trig  = m_mode[i] ? (src[i-1] && !m_srcq[i]) : src[i-1];
         np[i] = m_pend[i] || (trig && !m_insv[i]);
         ni[i] = m_insv[i];
      end
      if (req) begin
         a = int'(addr);
         if (a % 4 != 0) begin
            e_err = 1'b1;
         end else if (a < 'h300 && (a % 256) / 4 < (NS + 31) / 32) begin
            w = (a % 256) / 4;
            for (int j = 0; j < 32; j++) begin
               k = 32 * w + j + 1;
               if (k <= NS) begin
                  if (!we) begin
                     e_rdata[j] = (a < 'h100) ? m_pend[k] : (a < 'h200) ? m_en[k] : m_mode[k];
                  end else if (a >= 'h100 && a < 'h200) begin
                     m_en[k] = wdata[j];
                  end else if (a >= 'h200) begin
                     m_mode[k] = wdata[j];
                  end
               end
            end
         end else if (a >= 'h400 && a < 'h800 && (a - 'h400) / 4 < NS) begin
            k = (a - 'h400) / 4 + 1;
            if (!we) e_rdata = m_prio[k];
            else     m_prio[k] = int'(wdata % 8);
         end else if (a == 'h800) begin
            if (!we) e_rdata = m_thr;
            else     m_thr = int'(wdata % 8);
         end else if (a == 'h804) begin
            if (!we) begin
               e_rdata = m_id;
               if (m_id != 0) begin
                  np[m_id] = 0;
                  ni[m_id] = 1;
               end
            end else begin
               cid = int'(wdata % 128);
               if (cid >= 1 && cid <= NS) ni[cid] = 0;
            end
         end else begin
            e_err = 1'b1;
         end
      end
      m_pend = np;
      m_insv = ni;
      m_id   = nid;
      for (int i = 1; i <= NS; i++) m_srcq[i] = src[i-1];
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      chk("irq_id", irq_id, m_id);
      chk("irq", irq, m_id != 0);
      chk("rvalid", rvalid, e_rvalid);
      chk("rdata", rdata, e_rdata);
      chk("err", err, e_err);
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic reg_wr(input logic [11:0] a, input logic [31:0] d);
      req = 1'b1; we = 1'b1; addr = a; wdata = d;
      step();
      req = 1'b0; we = 1'b0;
   endtask

   task automatic reg_rd(input logic [11:0] a, output logic [31:0] d, output logic e);
      req = 1'b1; we = 1'b0; addr = a;
      step();
      d = rdata;
      e = err;
      req = 1'b0;
   endtask

   task automatic pulse(input int bit_idx);
      src[bit_idx] = 1'b1;
      step();
      src[bit_idx] = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      logic        e;
      int          op;

      // Reset state
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      chk("rst_irq", irq, 0);
      chk("rst_id", irq_id, 0);
      reg_rd(12'h100, d, e);
      chk("rst_enable", d, 0);

      // Level basic
      reg_wr(12'h410, 3);
      reg_wr(12'h800, 0);
      reg_wr(12'h100, 32'h10);
      src[4] = 1'b1;
      step();
      chk("lvl_irq_early", irq, 0);
      reg_rd(12'h000, d, e);
      chk("lvl_pending", d, 32'h10);
      chk("lvl_id", irq_id, 5);
      reg_rd(12'h804, d, e);
      chk("lvl_claim", d, 5);
      step();
      chk("lvl_irq_drop", irq, 0);
      reg_wr(12'h804, 5);
      step();
      chk("lvl_irq_after_cmp", irq, 0);
      reg_rd(12'h000, d, e);
      chk("lvl_repend", d, 32'h10);
      chk("lvl_reirq", irq_id, 5);
      reg_rd(12'h804, d, e);
      src[4] = 1'b0;
      reg_wr(12'h804, 5);
      idle(2);

      // Priority and tie-break
      reg_wr(12'h408, 2);
      reg_wr(12'h420, 6);
      reg_wr(12'h44C, 6);
      reg_wr(12'h100, 32'h0008_0104);
      src[2] = 1'b1; src[8] = 1'b1; src[19] = 1'b1;
      step();
      src = '0;
      idle(2);
      reg_rd(12'h804, d, e); chk("tie_claim1", d, 9);
      idle(2);
      reg_rd(12'h804, d, e); chk("tie_claim2", d, 20);
      idle(2);
      reg_rd(12'h804, d, e); chk("tie_claim3", d, 3);
      idle(2);
      reg_rd(12'h804, d, e); chk("tie_claim_none", d, 0);
      reg_rd(12'h000, d, e); chk("tie_pending", d, 0);
      reg_wr(12'h804, 9);
      reg_wr(12'h804, 20);
      reg_wr(12'h804, 3);

      // Threshold is strict
      reg_wr(12'h418, 4);
      reg_wr(12'h800, 4);
      reg_wr(12'h100, 32'h40);
      pulse(6);
      idle(3);
      chk("thr_blocked", irq, 0);
      reg_rd(12'h000, d, e); chk("thr_pending", d, 32'h40);
      reg_wr(12'h800, 3);
      step();
      chk("thr_id", irq_id, 7);
      chk("thr_irq", irq, 1);
      reg_rd(12'h804, d, e); chk("thr_claim", d, 7);
      reg_wr(12'h804, 7);
      reg_wr(12'h800, 0);

      // Edge mode
      reg_wr(12'h200, 32'h2);
      reg_wr(12'h404, 5);
      reg_wr(12'h100, 32'h2);
      pulse(1);
      idle(2);
      chk("edge_id", irq_id, 2);
      reg_rd(12'h804, d, e); chk("edge_claim", d, 2);
      for (int p = 0; p < 3; p++) begin
         pulse(1);
         step();
      end
      reg_rd(12'h000, d, e); chk("edge_dropped", d, 0);
      reg_wr(12'h804, 2);
      idle(3);
      reg_rd(12'h000, d, e); chk("edge_no_repend", d, 0);
      chk("edge_irq_idle", irq, 0);
      pulse(1);
      idle(2);
      chk("edge_new_id", irq_id, 2);

      // Simultaneous claim/complete with a fresh edge
      src[1] = 1'b1;
      reg_rd(12'h804, d, e);
      src[1] = 1'b0;
      chk("sim_claim", d, 2);
      reg_rd(12'h000, d, e); chk("sim_claim_pend", d, 0);
      src[1] = 1'b1;
      reg_wr(12'h804, 2);
      src[1] = 1'b0;
      reg_rd(12'h000, d, e); chk("sim_cmp_pend", d, 0);

      // Error responses
      reg_rd(12'h808, d, e); chk("err_808", e, 1); chk("err_808_data", d, 0);
      reg_rd(12'h500, d, e); chk("err_prio_oob", e, 1);
      reg_rd(12'h102, d, e); chk("err_misalign", e, 1);
      reg_rd(12'h300, d, e); chk("err_hole", e, 1);
      reg_wr(12'h000, 32'hFFFF_FFFF); chk("pend_wr_noerr", err, 0);

      // Invalid completes leave ID 2 in service
      pulse(1);
      idle(2);
      reg_rd(12'h804, d, e); chk("inv_claim", d, 2);
      reg_wr(12'h804, 0);
      reg_wr(12'h804, 65);
      reg_wr(12'h804, 7);
      pulse(1);
      idle(2);
      chk("inv_still_insv", irq, 0);

      // Reset mid-operation
      reg_wr(12'h100, 32'h12);
      src[4] = 1'b1;
      idle(3);
      src[4] = 1'b0;
      chk("rst_pre_id", irq_id, 5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst2_irq", irq, 0);
      chk("rst2_id", irq_id, 0);
      reg_rd(12'h000, d, e); chk("rst2_pending", d, 0);
      reg_rd(12'h100, d, e); chk("rst2_enable", d, 0);
      reg_rd(12'h200, d, e); chk("rst2_mode", d, 0);
      reg_rd(12'h410, d, e); chk("rst2_prio", d, 0);
      reg_rd(12'h800, d, e); chk("rst2_thr", d, 0);

      // Randomized phase, checked every cycle against the model
      for (int c = 0; c < 3000; c++) begin
         op  = int'($urandom_range(0, 9));
         src = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
         if (c == 1500) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
         end
         case (op)
            0, 1, 2: reg_rd(12'h804, d, e);
            3: reg_wr(12'h804, ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 70));
            4: reg_wr(12'(32'h100 + 4 * $urandom_range(0, 1)), $urandom);
            5: reg_wr(12'(32'h200 + 4 * $urandom_range(0, 1)), $urandom & $urandom);
            6: reg_wr(12'(32'h400 + 4 * $urandom_range(0, 63)), $urandom);
            7: reg_wr(12'h800, $urandom_range(0, 3));
            8: begin
               if ($urandom_range(0, 1) == 0)
                  reg_rd(12'(256 * $urandom_range(0, 3) + 4 * $urandom_range(0, 2)), d, e);
               else
                  reg_rd(12'(32'h400 + 4 * $urandom_range(0, 70)), d, e);
            end
            default: step();
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
